voter_5_session_ctrl: RTL and testbench

- Session controller that sequences the 5-voter block through a complete vote: open a timed voting window, accept one ballot per voter, close the window, tally, then hold the result.
- Sits between the DIP-switch and button inputs and the voter/7-segment display path.
- Its outputs yes_cnt, no_cnt and pass feed the display digits directly.

---
 rtl/voter_5_session_ctrl.sv | 106 ++++++++++
 tb/tb_voter_5_session_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/voter_5_session_ctrl.sv
// Five-voter session controller: opens a timed voting window, latches one ballot per voter, tallies and holds the result.
// Optional: define VOTER_EARLY_CLOSE_EN to close the window as soon as all five voters have cast.
module voter_5_session_ctrl #(
  parameter int unsigned WINDOW_CYCLES = 1000,
  parameter int unsigned CNT_W         = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [4:0] x,
  input  logic [4:0] press,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] yes_cnt,
  output logic [2:0] no_cnt,
  output logic [4:0] voted,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_VOTE  = 2'd1,
    S_TALLY = 2'd2,
    S_SHOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW_CYCLES - 1);

  state_t           st;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       ballot;
  logic [4:0]       press_d;
  logic [4:0]       new_cast;
  logic [2:0]       yes_sum;
  logic [2:0]       no_sum;
  logic             close_now;

  function automatic logic [2:0] popcnt5(input logic [4:0] v);
    logic [2:0] s;
    s = 3'd0;
    for (int i = 0; i < 5; i++) s = s + 3'(v[i]);
    return s;
  endfunction

  // Only a fresh rising edge from a voter who has not yet cast counts.
  assign new_cast = press & ~press_d & ~voted;
  assign yes_sum  = popcnt5(ballot & voted);
  assign no_sum   = popcnt5(~ballot & voted);

`ifdef VOTER_EARLY_CLOSE_EN
  assign close_now = (cnt == LAST_CNT) || (voted == 5'b11111);
`else
  assign close_now = (cnt == LAST_CNT);
`endif

  assign state = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= S_IDLE;
      cnt     <= '0;
      ballot  <= '0;
      press_d <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      yes_cnt <= 3'd0;
      no_cnt  <= 3'd0;
      voted   <= '0;
    end else begin
      press_d <= press;
      done    <= 1'b0;
      case (st)
        S_IDLE, S_SHOW: begin
          if (start) begin
            st      <= S_VOTE;
            busy    <= 1'b1;
            cnt     <= '0;
            ballot  <= '0;
            voted   <= '0;
            pass    <= 1'b0;
            yes_cnt <= 3'd0;
            no_cnt  <= 3'd0;
          end
        end
        S_VOTE: begin
          voted  <= voted | new_cast;
          ballot <= (ballot & ~new_cast) | (x & new_cast);
          if (close_now) st <= S_TALLY;
          else           cnt <= cnt + CNT_W'(1);
        end
        S_TALLY: begin
          yes_cnt <= yes_sum;
          no_cnt  <= no_sum;
          pass    <= (yes_sum >= 3'd3);
          st      <= S_SHOW;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voter_5_session_ctrl.sv
// Bench for voter_5_session_ctrl: directed sessions plus random traffic, checked every cycle against a timeline model.
module tb_voter_5_session_ctrl;

  localparam int unsigned W     = 16;
  localparam int unsigned CNT_W = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [4:0] x = 5'd0;
  logic [4:0] press = 5'd0;
  logic       busy, done, pass;
  logic [2:0] yes_cnt, no_cnt;
  logic [4:0] voted;
  logic [1:0] state;

  voter_5_session_ctrl #(.WINDOW_CYCLES(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .press(press),
    .busy(busy), .done(done), .pass(pass), .yes_cnt(yes_cnt),
    .no_cnt(no_cnt), .voted(voted), .state(state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: a session is a timeline measured by its age in cycles since it opened.
  bit       m_active = 1'b0;
  bit       m_shown  = 1'b0;
  bit       m_done   = 1'b0;
  int       m_age    = 0;
  int       m_close  = 0;
  bit [4:0] m_cast   = '0;
  bit [4:0] m_choice = '0;
  bit [4:0] m_prev   = '0;
  int       m_yes    = 0;
  int       m_no     = 0;
  bit       m_pass   = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    bit [4:0] e, cast, choice;
    bit active, shown, dn, ps;
    int age, close_at, ny, nn;
    if (!rst_n) begin
      m_active <= 0; m_shown <= 0; m_done <= 0; m_age <= 0; m_close <= 0;
      m_cast <= '0; m_choice <= '0; m_prev <= '0; m_yes <= 0; m_no <= 0; m_pass <= 0;
    end else begin
      e = press & ~m_prev;
      active = m_active; shown = m_shown; age = m_age; close_at = m_close;
      cast = m_cast; choice = m_choice; ny = m_yes; nn = m_no; ps = m_pass; dn = 0;
      if (!active) begin
        if (start) begin
          active = 1; age = 0; close_at = W; cast = '0; choice = '0;
          ny = 0; nn = 0; ps = 0;
        end
      end else if (age < close_at) begin
`ifdef VOTER_EARLY_CLOSE_EN
        if (cast == 5'h1f) close_at = age + 1;
`endif
        for (int i = 0; i < 5; i++)
          if (e[i] && !cast[i]) begin cast[i] = 1; choice[i] = x[i]; end
        age++;
      end else begin
        ny = 0; nn = 0;
        for (int i = 0; i < 5; i++) if (cast[i]) begin
          if (choice[i]) ny++; else nn++;
        end
        ps = (ny >= 3); active = 0; shown = 1; dn = 1;
      end
      m_prev <= press; m_active <= active; m_shown <= shown; m_done <= dn;
      m_age <= age; m_close <= close_at; m_cast <= cast; m_choice <= choice;
      m_yes <= ny; m_no <= nn; m_pass <= ps;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin : compare
    int es;
    if (rst_n) begin
      es = m_active ? ((m_age >= m_close) ? 2 : 1) : (m_shown ? 3 : 0);
      n_vec++;
      if (int'(state) != es || busy != m_active || done != m_done || pass != m_pass ||
          int'(yes_cnt) != m_yes || int'(no_cnt) != m_no || voted != m_cast) begin
        n_err++;
        $display("FAIL cycle %0d outputs: got st=%0d busy=%0d done=%0d pass=%0d yes=%0d no=%0d voted=%b, need st=%0d busy=%0d done=%0d pass=%0d yes=%0d no=%0d voted=%b",
                 cyc, state, busy, done, pass, yes_cnt, no_cnt, voted,
                 es, m_active, m_done, m_pass, m_yes, m_no, m_cast);
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, need %0d", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic open_session(output int t0);
    start = 1'b1; t0 = cyc; tick(); start = 1'b0;
  endtask

  task automatic cast(input int i, input bit v);
    x[i] = v; press[i] = 1'b1; tick(); press[i] = 1'b0; tick();
  endtask

  task automatic wait_done(input int t0, output int lat);
    lat = -1;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (done) begin lat = cyc - t0; break; end
    end
  endtask

  int t0, lat;

  initial begin
    // Reset state
    repeat (2) tick();
    chk("reset_state", int'(state), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_voted", int'(voted), 0);
    chk("reset_done", int'(done), 0);
    #2 rst_n = 1'b1;
    tick();

    // 3 yes, 2 no
    open_session(t0);
    cast(0, 1); cast(1, 1); cast(2, 1); cast(3, 0); cast(4, 0);
    wait_done(t0, lat);
`ifdef VOTER_EARLY_CLOSE_EN
    chk("t1_latency", lat, 12);
`else
    chk("t1_latency", lat, 18);
`endif
    chk("t1_yes", int'(yes_cnt), 3);
    chk("t1_no", int'(no_cnt), 2);
    chk("t1_pass", int'(pass), 1);
    chk("t1_voted", int'(voted), 31);
    tick();
    chk("t1_done_pulse", int'(done), 0);

    // 2 yes, 1 no, two abstain
    open_session(t0);
    cast(0, 1); cast(1, 1); cast(2, 0);
    wait_done(t0, lat);
    chk("t2_latency", lat, 18);
    chk("t2_yes", int'(yes_cnt), 2);
    chk("t2_no", int'(no_cnt), 1);
    chk("t2_pass", int'(pass), 0);
    chk("t2_voted", int'(voted), 7);

    // Second ballot from the same voter is ignored
    open_session(t0);
    cast(0, 1); cast(0, 0);
    wait_done(t0, lat);
    chk("t3_yes", int'(yes_cnt), 1);
    chk("t3_no", int'(no_cnt), 0);

    // Held button across reset and start; last-cycle edge counts, TALLY edge does not
    rst_n = 1'b0; press[4] = 1'b1; x[4] = 1'b1;
    tick(); #2 rst_n = 1'b1;
    tick();
    open_session(t0);
    tick(); tick();
    chk("t4_no_held_vote", int'(voted), 0);
    press[4] = 1'b0;
    while (cyc < t0 + 16) tick();
    press[4] = 1'b1;
    tick();
    x[3] = 1'b1; press[3] = 1'b1;
    tick();
    press = 5'd0;
    chk("t4_done", int'(done), 1);
    chk("t4_yes", int'(yes_cnt), 1);
    chk("t4_voted", int'(voted), 16);

    // Asynchronous reset mid-session
    open_session(t0);
    cast(0, 1); cast(1, 0); cast(2, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_state", int'(state), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_voted", int'(voted), 0);
    tick(); #2 rst_n = 1'b1;
    repeat (20) tick();
    chk("t5_idle", int'(state), 0);
    chk("t5_no_done", int'(done), 0);

    // Everyone votes in window cycle 4
    open_session(t0);
    while (cyc < t0 + 4) tick();
    x = 5'($urandom); press = 5'h1f;
    tick();
    press = 5'd0;
    wait_done(t0, lat);
`ifdef VOTER_EARLY_CLOSE_EN
    chk("t6_latency", lat, 7);
`else
    chk("t6_latency", lat, 18);
`endif

    // start held high restarts on every SHOW
    start = 1'b1;
    repeat (45) tick();
    start = 1'b0;

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      start = ($urandom_range(0, 15) == 0);
      x     = 5'($urandom);
      press = ($urandom_range(0, 3) == 0) ? 5'($urandom) : press & 5'($urandom);
      tick();
    end
    start = 1'b0; press = 5'd0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
